// File: rtl/spike_event_encoder.sv
// Converts an IEEE-754 single membrane potential into spike pulses with a refractory hold-off.
// Define SPIKE_TS_EN to build the timestamp counter and last_ts capture; otherwise last_ts is 0.
module spike_event_encoder #(
  parameter logic [31:0] THRESH         = 32'h3F800000,
  parameter int unsigned PULSE_CYCLES   = 2,
  parameter int unsigned REFRACT_CYCLES = 196
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] Vpostx1,
  output logic        spike,
  output logic        refract,
  output logic [15:0] spike_count,
  output logic [31:0] last_ts
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARM_WAIT = 3'd1;
  localparam logic [2:0] S_ARMED    = 3'd2;
  localparam logic [2:0] S_PULSE    = 3'd3;
  localparam logic [2:0] S_REFRACT  = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = S_IDLE,
    ARM_WAIT = S_ARM_WAIT,
    ARMED    = S_ARMED,
    PULSE    = S_PULSE,
    REFRACT  = S_REFRACT
  } state_e;

  localparam logic [7:0]  PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [15:0] REFR_LOAD  = 16'(REFRACT_CYCLES - 1);

  logic        v_nan;
  logic        v_ge;
  logic        above;
  logic        below;
  logic [30:0] v_mag;
  logic [30:0] t_mag;

  always_comb begin
    v_mag = Vpostx1[30:0];
    t_mag = THRESH[30:0];
    v_nan = (Vpostx1[30:23] == 8'hFF) && (Vpostx1[22:0] != '0);
    // Sign-magnitude ordering; +0 and -0 are equal, negatives compare reversed.
    if ((v_mag == '0) && (t_mag == '0)) begin
      v_ge = 1'b1;
    end else if (Vpostx1[31] != THRESH[31]) begin
      v_ge = ~Vpostx1[31];
    end else if (!Vpostx1[31]) begin
      v_ge = (v_mag >= t_mag);
    end else begin
      v_ge = (v_mag <= t_mag);
    end
    above = ~v_nan & v_ge;
    below = ~v_nan & ~v_ge;
  end

  state_e      state_q, state_d;
  logic [7:0]  pulse_cnt_q, pulse_cnt_d;
  logic [15:0] refr_cnt_q, refr_cnt_d;
  logic [15:0] count_q, count_d;
  logic        spike_q, spike_d;
  logic        refract_q, refract_d;
  logic        fire;

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    refr_cnt_d  = refr_cnt_q;
    fire        = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARM_WAIT;
        ARM_WAIT: begin
          if (below) state_d = ARMED;
        end
        ARMED: begin
          if (above) begin
            fire        = 1'b1;
            state_d     = PULSE;
            pulse_cnt_d = PULSE_LOAD;
          end
        end
        PULSE: begin
          if (pulse_cnt_q == '0) begin
            if (REFRACT_CYCLES == 0) begin
              state_d = ARM_WAIT;
            end else begin
              state_d    = REFRACT;
              refr_cnt_d = REFR_LOAD;
            end
          end else begin
            pulse_cnt_d = pulse_cnt_q - 8'd1;
          end
        end
        REFRACT: begin
          if (refr_cnt_q == '0) begin
            state_d = ARM_WAIT;
          end else begin
            refr_cnt_d = refr_cnt_q - 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    count_d = count_q;
    if (fire && (count_q != '1)) count_d = count_q + 16'd1;

    // Outputs are registered from the next state so they track state_q exactly.
    spike_d   = (state_d == PULSE);
    refract_d = (state_d == REFRACT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pulse_cnt_q <= '0;
      refr_cnt_q  <= '0;
      count_q     <= '0;
      spike_q     <= 1'b0;
      refract_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      refr_cnt_q  <= refr_cnt_d;
      count_q     <= count_d;
      spike_q     <= spike_d;
      refract_q   <= refract_d;
    end
  end

  assign spike       = spike_q;
  assign refract     = refract_q;
  assign spike_count = count_q;

`ifdef SPIKE_TS_EN
  logic [31:0] ts_q, ts_d;
  logic [31:0] last_ts_q, last_ts_d;

  always_comb begin
    ts_d      = ts_q;
    last_ts_d = last_ts_q;
    if (enable) ts_d = ts_q + 32'd1;
    // Capture the pre-increment value seen at the crossing edge.
    if (fire) last_ts_d = ts_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q      <= '0;
      last_ts_q <= '0;
    end else begin
      ts_q      <= ts_d;
      last_ts_q <= last_ts_d;
    end
  end

  assign last_ts = last_ts_q;
`else
  assign last_ts = '0;
`endif

endmodule

// File: tb/tb_spike_event_encoder.sv
// Bench for spike_event_encoder: a real-valued behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_spike_event_encoder;

  localparam logic [31:0] D_THR = 32'h3F800000;
  localparam int unsigned D_P   = 2;
  localparam int unsigned D_R   = 196;
  localparam logic [31:0] N_THR = 32'hC2480000;
  localparam int unsigned N_P   = 1;
  localparam int unsigned N_R   = 0;

`ifdef SPIKE_TS_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  localparam logic [31:0] F_0P5  = 32'h3F000000;
  localparam logic [31:0] F_1P0  = 32'h3F800000;
  localparam logic [31:0] F_1P5  = 32'h3FC00000;
  localparam logic [31:0] F_2P0  = 32'h40000000;
  localparam logic [31:0] F_M70  = 32'hC28C0000;
  localparam logic [31:0] F_M40  = 32'hC2200000;
  localparam logic [31:0] F_M50  = 32'hC2480000;
  localparam logic [31:0] F_NAN  = 32'h7FC00000;
  localparam logic [31:0] F_PINF = 32'h7F800000;
  localparam logic [31:0] F_NINF = 32'hFF800000;
  localparam logic [31:0] F_NZ   = 32'h80000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] vin;
  logic        spike, refract, n_spike, n_refract;
  logic [15:0] count, n_count;
  logic [31:0] last_ts, n_last_ts;

  always #5 clk = ~clk;

  spike_event_encoder #(.THRESH(D_THR), .PULSE_CYCLES(D_P), .REFRACT_CYCLES(D_R)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .Vpostx1(vin),
    .spike(spike), .refract(refract), .spike_count(count), .last_ts(last_ts)
  );

  spike_event_encoder #(.THRESH(N_THR), .PULSE_CYCLES(N_P), .REFRACT_CYCLES(N_R)) u_neg (
    .clk(clk), .reset(reset), .enable(enable), .Vpostx1(vin),
    .spike(n_spike), .refract(n_refract), .spike_count(n_count), .last_ts(n_last_ts)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Model: after a crossing the encoder is busy for P+R cycles (pulse first, then
  // refractory); once idle it needs one below-sample before an above-sample fires.
  typedef struct packed {
    bit        active;
    bit        armed;
    bit [31:0] hold;
    bit [16:0] count;
    bit [31:0] ts;
    bit [31:0] last;
  } mst_t;

  function automatic bit is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction

  function automatic real f2r(input logic [31:0] b);
    int  e = int'(b[30:23]);
    real m;
    if (e == 255)    m = 1.0e300;
    else if (e == 0) m = real'(b[22:0]) * 2.0 ** (-149);
    else             m = (1.0 + real'(b[22:0]) / 8388608.0) * 2.0 ** (e - 127);
    return b[31] ? -m : m;
  endfunction

  function automatic mst_t step(input mst_t s, input logic rst, input logic en,
                               input logic [31:0] v, input logic [31:0] thr,
                               input int unsigned p, input int unsigned r);
    mst_t n = s;
    bit   up   = !is_nan(v) && (f2r(v) >= f2r(thr));
    bit   down = !is_nan(v) && (f2r(v) <  f2r(thr));
    if (rst) begin
      n = '0;
    end else if (!en) begin
      n.active = 1'b0;
      n.armed  = 1'b0;
      n.hold   = '0;
    end else begin
      n.ts = s.ts + 32'd1;
      if (!s.active)         n.active = 1'b1;
      else if (s.hold != 0)  n.hold   = s.hold - 32'd1;
      else if (!s.armed)     n.armed  = down;
      else if (up) begin
        n.hold  = p + r;
        n.armed = 1'b0;
        if (s.count < 17'd65535) n.count = s.count + 17'd1;
        n.last  = s.ts;
      end
    end
    return n;
  endfunction

  mst_t md = '0;
  mst_t mn = '0;

  always @(posedge clk) begin
    md <= step(md, reset, enable, vin, D_THR, D_P, D_R);
    mn <= step(mn, reset, enable, vin, N_THR, N_P, N_R);
  end

  function automatic logic [31:0] ts_exp(input logic [31:0] v);
    return TS_ON ? v : 32'd0;
  endfunction

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc spike",     32'(spike),     32'(md.hold > D_R));
      chk("cyc refract",   32'(refract),   32'((md.hold != 0) && (md.hold <= D_R)));
      chk("cyc count",     32'(count),     32'(md.count));
      chk("cyc last_ts",   last_ts,        ts_exp(md.last));
      chk("cyc n_spike",   32'(n_spike),   32'(mn.hold > N_R));
      chk("cyc n_refract", 32'(n_refract), 32'((mn.hold != 0) && (mn.hold <= N_R)));
      chk("cyc n_count",   32'(n_count),   32'(mn.count));
      chk("cyc n_last_ts", n_last_ts,      ts_exp(mn.last));
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int unsigned len;
    int unsigned hi;
    reset  = 1'b1;
    enable = 1'b0;
    vin    = F_0P5;
    cyc(3);
    cmp_en = 1'b1;
    chk("rst spike",   32'(spike),   32'd0);
    chk("rst refract", 32'(refract), 32'd0);
    chk("rst count",   32'(count),   32'd0);
    chk("rst last_ts", last_ts,      32'd0);

    // Basic spike: three 0.5 samples then 1.5; crossing edge sees ts = 3.
    reset  = 1'b0;
    enable = 1'b1;
    cyc(3);
    vin = F_1P5;
    cyc(1);
    chk("basic spike c1", 32'(spike), 32'd1);
    chk("basic count",    32'(count), 32'd1);
    chk("basic last_ts",  last_ts,    ts_exp(32'd3));
    cyc(1);
    chk("basic spike c2", 32'(spike), 32'd1);
    cyc(1);
    chk("basic spike end", 32'(spike),   32'd0);
    chk("basic refract",   32'(refract), 32'd1);

    // Refractory length, with a below/above wiggle inside it that must be ignored.
    len = 1;
    for (int unsigned i = 0; i < 400 && refract === 1'b1; i++) begin
      if (len == 40)  vin = F_0P5;
      if (len == 100) vin = F_1P5;
      cyc(1);
      if (refract === 1'b1) len++;
    end
    chk("refract len",   len,        32'd196);
    chk("refract count", 32'(count), 32'd1);

    cyc(5);
    chk("no rearm above", 32'(count), 32'd1);
    vin = F_0P5;
    cyc(1);
    vin = F_1P0;
    cyc(1);
    chk("spike2 at thresh", 32'(spike), 32'd1);
    chk("spike2 count",     32'(count), 32'd2);

    // Disable during the pulse truncates it and holds the count.
    enable = 1'b0;
    cyc(1);
    chk("dis spike", 32'(spike), 32'd0);
    chk("dis count", 32'(count), 32'd2);

    // Start-above: 2.0 for 50 cycles never fires until a below sample.
    vin    = F_2P0;
    enable = 1'b1;
    cyc(50);
    chk("above no spike", 32'(count), 32'd2);
    vin = F_0P5;
    cyc(1);
    vin = F_2P0;
    cyc(1);
    chk("above spike", 32'(spike), 32'd1);
    hi = 0;
    for (int unsigned i = 0; i < 250; i++) begin
      cyc(1);
      if (spike === 1'b1) hi++;
    end
    chk("above one pulse", hi,         32'd1);
    chk("above count",     32'(count), 32'd3);

    // Reset in the refractory period clears everything.
    vin = F_0P5;
    cyc(1);
    vin = F_2P0;
    cyc(21);
    chk("pre-rst refract", 32'(refract), 32'd1);
    reset = 1'b1;
    cyc(1);
    chk("mid rst count",   32'(count),   32'd0);
    chk("mid rst last_ts", last_ts,      32'd0);
    chk("mid rst refract", 32'(refract), 32'd0);
    chk("mid rst spike",   32'(spike),   32'd0);

    // Timestamp: 25 enabled edges after reset, crossing on the 26th.
    vin = F_0P5;
    cyc(1);
    reset = 1'b0;
    cyc(25);
    vin = F_1P5;
    cyc(1);
    chk("ts spike",   32'(spike), 32'd1);
    chk("ts last_ts", last_ts,    ts_exp(32'd25));

    // Negative threshold instance (-50.0, 1-cycle pulse, no refractory).
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    vin   = F_M70;
    cyc(2);
    vin = F_M40;
    cyc(1);
    chk("neg spike",   32'(n_spike), 32'd1);
    chk("neg count",   32'(n_count), 32'd1);
    chk("neg last_ts", n_last_ts,    ts_exp(32'd2));
    cyc(1);
    chk("neg pulse end", 32'(n_spike),   32'd0);
    chk("neg no refr",   32'(n_refract), 32'd0);
    vin = F_NAN;
    cyc(10);
    vin = F_M40;
    cyc(3);
    chk("nan no arm", 32'(n_count), 32'd1);
    vin = F_M70;
    cyc(1);
    vin = F_NAN;
    cyc(5);
    chk("nan no fire", 32'(n_count), 32'd1);
    vin = F_PINF;
    cyc(1);
    chk("pinf spike", 32'(n_spike), 32'd1);
    chk("pinf count", 32'(n_count), 32'd2);
    cyc(1);
    vin = F_NINF;
    cyc(1);
    vin = F_M50;
    cyc(1);
    chk("eq neg thr spike", 32'(n_spike), 32'd1);
    cyc(1);
    vin = F_NINF;
    cyc(1);
    vin = F_NZ;
    cyc(1);
    chk("neg zero spike", 32'(n_spike), 32'd1);
    chk("neg zero count", 32'(n_count), 32'd4);
    cyc(2);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
